uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of the UART receiver.
- Drains each completed byte (rx_ready/rx_data) into a small FIFO and acknowledges it with rx_clear, so the receiver is always free for the next frame.
- Presents a show-ahead pop interface and status to the UART MMIO register block.
- Overrun is sticky-flagged instead of silently lost.

---
 rtl/uart_rx_fifo_pkg.sv | 23 ++
 rtl/sync_fifo_mem.sv | 27 ++
 rtl/uart_rx_fifo.sv | 116 +++++++++++
 tb/tb_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and types: data width, RX FIFO default depth,
// MMIO register offsets and the per-cycle FIFO operation encoding.
package uart_rx_fifo_pkg;

  localparam int unsigned UART_DATA_W                = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH_DEFAULT = 8;

  // Byte offsets of the RX registers inside the UART MMIO block
  localparam logic [7:0] UART_REG_RX_DATA   = 8'h00;
  localparam logic [7:0] UART_REG_RX_STATUS = 8'h04;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x UART_DATA_W register array: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module sync_fifo_mem
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: drains receiver bytes into a show-ahead FIFO with a
// sticky overrun flag. Optional threshold interrupt via UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = UART_RX_FIFO_DEPTH_DEFAULT,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_ready,
  input  logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_clear,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [AW:0]            count,
  output logic                   overrun,
  input  logic                   ovr_clear
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  input  logic [AW:0]            level,
  output logic                   irq
`endif
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          push_ok, pop_ok, drop;
  fifo_op_e      op;

  assign rx_clear = rx_ready;
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign overrun  = overrun_q;

  always_comb begin
    pop_ok    = rd_en && !empty;
    // A full FIFO still accepts a byte when the same cycle frees a slot
    push_ok   = rx_ready && (!full || pop_ok);
    drop      = rx_ready && !push_ok;
    op        = fifo_op(push_ok, pop_ok);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    unique case (op)
      FIFO_PUSH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      FIFO_POP: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      FIFO_BOTH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      FIFO_IDLE: ;
    endcase
    overrun_d = drop | (overrun_q & ~ovr_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (rx_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

`ifdef UART_RX_FIFO_IRQ_EN
  logic [AW:0] level_eff;
  logic        irq_q, irq_d;

  always_comb begin
    level_eff = (level == '0) ? (AW+1)'(1) : level;
    irq_d     = (count_d >= level_eff) | overrun_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=8); the irq checks
// are compiled in when UART_RX_FIFO_IRQ_EN is defined.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_clear;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overrun;
  logic       ovr_clear;
`ifdef UART_RX_FIFO_IRQ_EN
  logic [3:0] level;
  logic       irq;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_clear  (rx_clear),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overrun   (overrun),
    .ovr_clear (ovr_clear)
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    .level     (level),
    .irq       (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    #1 chk("rx_clear_hi", 32'(rx_clear), 32'd1);
    tick();
    rx_ready = 1'b0;
    #1 chk("rx_clear_lo", 32'(rx_clear), 32'd0);
  endtask

  task automatic pop(input logic [7:0] b);
    rd_en = 1'b1;
    #1 chk("pop_data", 32'(rd_data), 32'(b));
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    rd_en     = 1'b0;
    ovr_clear = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
    level     = 4'd0;
`endif
    #2;
    chk("rst_empty",   32'(empty),    32'd1);
    chk("rst_full",    32'(full),     32'd0);
    chk("rst_count",   32'(count),    32'd0);
    chk("rst_overrun", 32'(overrun),  32'd0);
    chk("rst_rxclr",   32'(rx_clear), 32'd0);
`ifdef UART_RX_FIFO_IRQ_EN
    chk("rst_irq",     32'(irq),      32'd0);
`endif
    tick();
    tick();
    reset = 1'b0;

    // Basic in-order push/pop
    push(8'h55);
    chk("lat_count", 32'(count),   32'd1);
    chk("lat_data",  32'(rd_data), 32'h55);
    push(8'hA3);
    push(8'h0F);
    chk("three_count", 32'(count), 32'd3);
    chk("three_empty", 32'(empty), 32'd0);
    pop(8'h55);
    pop(8'hA3);
    pop(8'h0F);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);

    // Fill, overflow, drain, clear overrun
    for (int i = 0; i < 8; i++) push(8'(i));
    chk("fill_full",  32'(full),    32'd1);
    chk("fill_count", 32'(count),   32'd8);
    chk("fill_ovr",   32'(overrun), 32'd0);
    push(8'hFF);
    chk("ovf_ovr",   32'(overrun), 32'd1);
    chk("ovf_count", 32'(count),   32'd8);
    chk("ovf_full",  32'(full),    32'd1);
    for (int i = 0; i < 8; i++) pop(8'(i));
    chk("ovf_drain_empty", 32'(empty),   32'd1);
    chk("ovr_sticky",      32'(overrun), 32'd1);
    ovr_clear = 1'b1;
    tick();
    ovr_clear = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(8'(i));
    rx_data  = 8'h99;
    rx_ready = 1'b1;
    rd_en    = 1'b1;
    #1 chk("sim_full_data", 32'(rd_data), 32'h00);
    tick();
    rx_ready = 1'b0;
    rd_en    = 1'b0;
    chk("sim_full_count", 32'(count),   32'd8);
    chk("sim_full_ovr",   32'(overrun), 32'd0);
    chk("sim_full_full",  32'(full),    32'd1);
    for (int i = 1; i < 8; i++) pop(8'(i));
    pop(8'h99);
    chk("sim_full_empty", 32'(empty), 32'd1);

    // Empty FIFO: ignored pop, then push+pop together
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("empty_pop_count", 32'(count),   32'd0);
    chk("empty_pop_empty", 32'(empty),   32'd1);
    chk("empty_pop_ovr",   32'(overrun), 32'd0);
    rx_data  = 8'h42;
    rx_ready = 1'b1;
    rd_en    = 1'b1;
    tick();
    rx_ready = 1'b0;
    rd_en    = 1'b0;
    chk("sim_empty_count", 32'(count),   32'd1);
    chk("sim_empty_data",  32'(rd_data), 32'h42);
    pop(8'h42);
    chk("sim_empty_drain", 32'(count), 32'd0);

    // Pointer wrap with interleaved traffic
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h10 + i));
      chk("wrap_count1", 32'(count), 32'd1);
      pop(8'(8'h10 + i));
      chk("wrap_count0", 32'(count), 32'd0);
    end

`ifdef UART_RX_FIFO_IRQ_EN
    level = 4'd4;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    chk("irq_below", 32'(irq), 32'd0);
    push(8'h04);
    chk("irq_rise",       32'(irq),   32'd1);
    chk("irq_rise_count", 32'(count), 32'd4);
    pop(8'h01);
    chk("irq_fall",       32'(irq),   32'd0);
    chk("irq_fall_count", 32'(count), 32'd3);
    pop(8'h02);
    pop(8'h03);
    pop(8'h04);
    level = 4'd0;
    push(8'h05);
    chk("irq_level0", 32'(irq), 32'd1);
    pop(8'h05);
    chk("irq_level0_off", 32'(irq), 32'd0);
`endif

    // Asynchronous reset mid-operation with count=3 and overrun set
    for (int i = 0; i < 8; i++) push(8'(i));
    push(8'hEE);
    for (int i = 0; i < 5; i++) pop(8'(i));
    chk("pre_rst_count", 32'(count),   32'd3);
    chk("pre_rst_ovr",   32'(overrun), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(count),   32'd0);
    chk("arst_empty", 32'(empty),   32'd1);
    chk("arst_ovr",   32'(overrun), 32'd0);
    chk("arst_full",  32'(full),    32'd0);
`ifdef UART_RX_FIFO_IRQ_EN
    chk("arst_irq",   32'(irq),     32'd0);
`endif
    tick();
    reset = 1'b0;
    push(8'hAB);
    chk("post_rst_count", 32'(count), 32'd1);
    pop(8'hAB);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
